data_ram_resp: RTL and testbench
================================

DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15; extra wait states inserted before each response.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 ce  in  1  request valid from the memory stage; held stable by the master until ready.
REQ-006 we  in  1  1 = write, 0 = read.
REQ-007 addr  in  32  byte address.
REQ-008 sel  in  4  byte-lane select; big-endian (sel[3] = bits 31:24 = byte at addr+0).
REQ-009 data_i  in  32  write data.
REQ-010 data_o  out  32  read data; registered.
REQ-011 ready  out  1  one-cycle pulse: request completed.
REQ-012 stall_req  out  1  pipeline stall request to the control unit.
REQ-013 err  out  1  one-cycle pulse coincident with ready: request rejected.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; IDLE is the only state that accepts requests.
REQ-015 In IDLE with ce=1, block SHALL latch addr, we, sel and data_i at the clock edge, load the wait counter with WAIT_CYCLES, and go to WAIT (or to RESP if WAIT_CYCLES=0).
REQ-016 In WAIT, counter decrements each cycle; transition to RESP on the edge where counter reaches 0 (exactly WAIT_CYCLES cycles in WAIT).
REQ-017 In RESP, ready=1 for exactly one cycle; next state is IDLE unconditionally, whatever the value of ce.
REQ-018 Latency: ready asserts WAIT_CYCLES+1 cycles after the accepting edge; minimum 1.
REQ-019 stall_req = 1 while (state=IDLE and ce=1) or state=WAIT; 0 in RESP and in IDLE with ce=0.
REQ-020 ce/we/addr/sel/data_i changes while in WAIT or RESP SHALL be ignored; only latched values are used.
REQ-021 Error condition on latched request: addr[1:0]!=0, sel=0, or addr[31:ADDR_W+2]!=0.
REQ-022 Write with no error: at the RESP edge, each lane with sel bit =1 SHALL be written from the matching data_i lane at word addr[ADDR_W+1:2]; lanes with sel=0 are unchanged.
REQ-023 Read with no error: at the RESP edge, data_o SHALL load the addressed word with unselected lanes forced to 0x00.
REQ-024 Write: data_o SHALL load 0 at the RESP edge.
REQ-025 Error: no memory write; data_o loads 0; err=1 together with ready.
REQ-026 data_o SHALL hold its value until the next RESP edge or reset.
REQ-027 Read-after-write to the same word in back-to-back requests SHALL return the newly written data.
REQ-028 ready and err SHALL be 0 in every state other than RESP.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, counter=0, data_o=0, ready=0, err=0; stall_req follows REQ-019 from IDLE.
REQ-030 Reset during WAIT or RESP aborts the request: no memory write occurs and no ready pulse follows.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 WAIT_CYCLES=1: write addr=0x10, sel=1111, data=0xDEADBEEF, then read 0x10 sel=1111 -> ready 2 cycles after each acceptance, read data_o=0xDEADBEEF, err=0.
REQ-033 Byte write addr=0x10 sel=0010 data=0x0000AA00 over 0xDEADBEEF, then full read -> data_o=0xDEADAAEF; read with sel=1100 -> data_o=0xDEAD0000.
REQ-034 Misaligned addr=0x12, and sel=0000, and addr=0x00001000 with ADDR_W=10 -> ready=err=1, data_o=0, target words unchanged on later read.
REQ-035 WAIT_CYCLES=0: ce held high over three consecutive requests -> stall_req 1 in each accept cycle, 0 in each RESP cycle; ready pulses one cycle apart with an IDLE cycle between.
REQ-036 WAIT_CYCLES=3: write to 0x20, rst asserted one cycle in WAIT, then read 0x20 -> no ready for the aborted write; read returns the pre-write value.
REQ-037 Inputs changed during WAIT -> response reflects the latched request only.

Source files
------------

// File: rtl/data_ram_resp.sv
// data_ram_resp: single-port data RAM behind a request/response handshake.
// Each request is latched in IDLE, optionally delayed by WAIT_CYCLES wait
// states, and completed in RESP with a one-cycle ready pulse. Malformed
// requests (misaligned, empty lane select, out of range) complete with err.
module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready,
    output logic        stall_req,
    output logic        err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [3:0]          req_sel;
    logic [31:0]         req_data;
    logic                req_err;
    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         lane_mask;
    logic [31:0]         mem [0:DEPTH-1];

    // Validity of the latched request and the word/lane it targets.
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_sel == 4'b0000) ||
                       (req_addr[31:ADDR_W+2] != '0);
    assign word_idx  = req_addr[ADDR_W+1:2];
    assign lane_mask = {{8{req_sel[3]}}, {8{req_sel[2]}}, {8{req_sel[1]}}, {8{req_sel[0]}}};

    // State register and wait-state counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && ce) begin
                cnt <= WAIT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Request capture; only IDLE accepts, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && ce) begin
            req_we   <= we;
            req_addr <= addr;
            req_sel  <= sel;
            req_data <= data_i;
        end
    end

    // Next-state decode and handshake outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        err       = 1'b0;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                stall_req = ce;
                if (ce) begin
                    state_nx = (WAIT_INIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                ready    = 1'b1;
                err      = req_err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Byte-lane write at the RESP edge; a reset on that edge aborts it.
    // NOTE: the memory array has no reset; its contents survive rst and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[word_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // Read data register: masked word for good reads, zero for writes and errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= 32'd0;
        end else if (state == RESP) begin
            data_o <= (!req_we && !req_err) ? (mem[word_idx] & lane_mask) : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: three instances (WAIT_CYCLES = 1, 0, 3) share one
// clock. Expected responses are pushed to a scoreboard when a request is
// driven and popped by a monitor when ready pulses; data_o is compared on the
// following cycle, after its register has loaded.
module tb_data_ram_resp;

    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst    [3];
    logic        ce     [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [3:0]  sel    [3];
    logic [31:0] data_i [3];
    logic [31:0] data_o [3];
    logic        ready  [3];
    logic        stall_req [3];
    logic        err    [3];

    exp_t        sb_q[$];
    logic [31:0] model [3][1024];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        pend = 1'b0;
    int          pend_k = 0;
    logic [31:0] pend_data = 32'd0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_ram_resp #(
            .ADDR_W      (10),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .ce        (ce[g]),
            .we        (we[g]),
            .addr      (addr[g]),
            .sel       (sel[g]),
            .data_i    (data_i[g]),
            .data_o    (data_o[g]),
            .ready     (ready[g]),
            .stall_req (stall_req[g]),
            .err       (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Reference behaviour: error rule, lane masking, memory update, push.
    task automatic push_expect(input int k, input logic w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d);
        exp_t        e;
        logic        bad;
        logic [31:0] m;
        int          idx;
        bad = (a[1:0] != 2'b00) || (s == 4'b0000) || (a[31:12] != 20'd0);
        m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        idx = int'(a[11:2]);
        e.inst = k;
        e.err  = bad;
        e.data = 32'd0;
        if (!bad && w) model[k][idx] = (model[k][idx] & ~m) | (d & m);
        if (!bad && !w) e.data = model[k][idx] & m;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int k, input logic c, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        ce[k] = c; we[k] = w; addr[k] = a; sel[k] = s; data_i[k] = d;
    endtask

    // One request from an idle DUT, called and returning on a negedge.
    task automatic do_req(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d, input bit scramble);
        int lat;
        push_expect(k, w, a, s, d);
        drive(k, 1'b1, w, a, s, d);
        #1 check("stall_accept", 32'(stall_req[k]), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!ready[k] && lat < 40) begin
            check("stall_wait", 32'(stall_req[k]), 32'd1);
            if (scramble) begin
                drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                      4'($urandom_range(0, 15)), $urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(wait_of(k) + 1));
        check("stall_resp", 32'(stall_req[k]), 32'd0);
        ce[k] = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pop on ready, compare err now and data_o one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            check("data_o", data_o[pend_k], pend_data);
            pend = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (err[k] && !ready[k]) check("err_without_ready", 32'd1, 32'd0);
            if (ready[k]) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ready", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_inst", 32'(k), 32'(e.inst));
                    check("err", 32'(err[k]), 32'(e.err));
                    pend      = 1'b1;
                    pend_k    = k;
                    pend_data = e.data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            drive(k, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_data_o", data_o[k], 32'd0);
            check("rst_stall", 32'(stall_req[k]), 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        // WAIT_CYCLES=1: full and byte-lane access, error cases, scrambled inputs.
        do_req(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b0);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h10, 4'b1100, 32'h0, 1'b0);
        do_req(0, 1'b1, 32'h0, 4'b1111, 32'h12345678, 1'b0);
        do_req(0, 1'b1, 32'h12, 4'b1111, 32'hFFFFFFFF, 1'b0);
        do_req(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0);
        do_req(0, 1'b1, 32'h00001000, 4'b1111, 32'hCAFEF00D, 1'b0);
        do_req(0, 1'b0, 32'h12, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1);
        do_req(0, 1'b0, 32'h0, 4'b0101, 32'h0, 1'b1);

        // WAIT_CYCLES=0: ce held high across three back-to-back writes.
        for (int j = 0; j < 3; j++) begin
            push_expect(1, 1'b1, 32'(8 + 4 * j), 4'b1111, 32'hA5A50000 + 32'(j));
            drive(1, 1'b1, 1'b1, 32'(8 + 4 * j), 4'b1111, 32'hA5A50000 + 32'(j));
            #1 check("b2b_stall_accept", 32'(stall_req[1]), 32'd1);
            check("b2b_idle_ready", 32'(ready[1]), 32'd0);
            @(negedge clk);
            check("b2b_resp_ready", 32'(ready[1]), 32'd1);
            check("b2b_resp_stall", 32'(stall_req[1]), 32'd0);
            @(negedge clk);
        end
        ce[1] = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) do_req(1, 1'b0, 32'(8 + 4 * j), 4'b1111, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'hC, 4'b0001, 32'h000000FF, 1'b0);
        do_req(1, 1'b0, 32'hC, 4'b1111, 32'h0, 1'b0);

        // WAIT_CYCLES=3: reset during WAIT aborts a write.
        do_req(2, 1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
        drive(2, 1'b1, 1'b1, 32'h20, 4'b1111, 32'h55667788);
        @(negedge clk);
        check("abort_in_wait_stall", 32'(stall_req[2]), 32'd1);
        ce[2]  = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("abort_data_o", data_o[2], 32'd0);
        check("abort_stall", 32'(stall_req[2]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_ready", 32'(ready[2]), 32'd0);
            @(negedge clk);
        end
        do_req(2, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
        do_req(2, 1'b0, 32'h20, 4'b0011, 32'h0, 1'b1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
